// File: rtl/audio_adc_rx_pkg.sv
// audio_adc_rx_pkg: shared state encoding, default sizes and counter-width helper for the I2S ADC receiver
package audio_adc_rx_pkg;
  typedef enum logic [1:0] {ALIGN, LEFT, RIGHT} rx_state_e;
  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_SLOT_W = 32;
  localparam int DEF_SYNC_STAGES = 2;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/audio_adc_rx_pin_sync.sv
// audio_adc_rx_pin_sync: synchronises the three I2S pins and produces a one-cycle bclk rising-edge strobe
module audio_adc_rx_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic bclk_i,
  input  logic lrck_i,
  input  logic dat_i,
  output logic ev_o,
  output logic lrck_o,
  output logic dat_o
);
  logic [STAGES-1:0] bclk_q, lrck_q, dat_q;
  logic bclk_prev_q, ev_q, lrck_s_q, dat_s_q;
  // synchroniser chains; lrck/dat are re-registered with the strobe so all three stay cycle-aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_q <= '0;
      lrck_q <= '0;
      dat_q <= '0;
      bclk_prev_q <= 1'b0;
      ev_q <= 1'b0;
      lrck_s_q <= 1'b0;
      dat_s_q <= 1'b0;
    end else begin
      bclk_q <= {bclk_q[STAGES-2:0], bclk_i};
      lrck_q <= {lrck_q[STAGES-2:0], lrck_i};
      dat_q <= {dat_q[STAGES-2:0], dat_i};
      bclk_prev_q <= bclk_q[STAGES-1];
      ev_q <= bclk_q[STAGES-1] & ~bclk_prev_q;
      lrck_s_q <= lrck_q[STAGES-1];
      dat_s_q <= dat_q[STAGES-1];
    end
  end
  assign ev_o = ev_q;
  assign lrck_o = lrck_s_q;
  assign dat_o = dat_s_q;
endmodule

// File: rtl/audio_adc_rx.sv
// audio_adc_rx: I2S ADC receiver deserialising stereo words into a left/right pair with valid/ready output
module audio_adc_rx
  import audio_adc_rx_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int SLOT_W = DEF_SLOT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                aud_bclk,
  input  logic                aud_adclrck,
  input  logic                aud_adcdat,
  input  logic                enable,
  output logic [SAMPLE_W-1:0] left_data,
  output logic [SAMPLE_W-1:0] right_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  output logic                frame_err
);
  localparam int CW = cnt_w(SLOT_W);
  localparam logic [CW-1:0] SW = CW'(SAMPLE_W);
  localparam logic [CW-1:0] SW1 = CW'(SAMPLE_W - 1);
  localparam logic [CW-1:0] SLOT = CW'(SLOT_W);
  logic ev, lrck_s, dat_s;
  rx_state_e state_q, state_d;
  logic lrck_prev_q, lrck_prev_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0] sh_q, sh_d, word, left_hold_q, left_hold_d;
  logic [SAMPLE_W-1:0] left_q, left_d, right_q, right_d;
  logic valid_q, valid_d, overrun_q, overrun_d, ferr_q, ferr_d;
  logic chg, short_word, slot_end, commit, bad_commit, load;
  audio_adc_rx_pin_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .bclk_i(aud_bclk),
    .lrck_i(aud_adclrck),
    .dat_i(aud_adcdat),
    .ev_o(ev),
    .lrck_o(lrck_s),
    .dat_o(dat_s)
  );
  // frame tracking, word assembly and output-pair handoff; the ev after an lrck change is the I2S delay slot
  always_comb begin
    chg = ev && (lrck_s != lrck_prev_q);
    short_word = bit_cnt_q < SW1;
    slot_end = ev && !chg && (bit_cnt_q == SLOT - CW'(1));
    word = (bit_cnt_q >= SW) ? sh_q : sh_q << (SW - bit_cnt_q);
    commit = enable && chg && (state_q != ALIGN) && !short_word;
    bad_commit = enable && chg && (state_q != ALIGN) && short_word;
    load = commit && (state_q == RIGHT) && (!valid_q || sample_ready);
    state_d = (!enable || slot_end || bad_commit) ? ALIGN :
              !chg ? state_q :
              (state_q == ALIGN) ? (lrck_s ? ALIGN : LEFT) :
              (state_q == LEFT) ? RIGHT : LEFT;
    lrck_prev_d = ev ? lrck_s : lrck_prev_q;
    bit_cnt_d = !ev ? bit_cnt_q : chg ? '0 : (bit_cnt_q == SLOT) ? bit_cnt_q : bit_cnt_q + CW'(1);
    sh_d = !ev ? sh_q : chg ? '0 : (bit_cnt_q < SW) ? {sh_q[SAMPLE_W-2:0], dat_s} : sh_q;
    left_hold_d = (commit && state_q == LEFT) ? word : left_hold_q;
    left_d = load ? left_hold_q : left_q;
    right_d = load ? word : right_q;
    valid_d = load ? 1'b1 : (valid_q && sample_ready) ? 1'b0 : valid_q;
    overrun_d = commit && (state_q == RIGHT) && !load;
    ferr_d = slot_end || bad_commit;
  end
  // state and output registers; reset discards any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ALIGN;
      lrck_prev_q <= 1'b0;
      bit_cnt_q <= '0;
      sh_q <= '0;
      left_hold_q <= '0;
      left_q <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lrck_prev_q <= lrck_prev_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q <= sh_d;
      left_hold_q <= left_hold_d;
      left_q <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
      overrun_q <= overrun_d;
      ferr_q <= ferr_d;
    end
  end
  assign left_data = left_q;
  assign right_data = right_q;
  assign sample_valid = valid_q;
  assign overrun = overrun_q;
  assign frame_err = ferr_q;
endmodule

// File: tb/tb_audio_adc_rx.sv
// tb_audio_adc_rx: directed I2S frames against audio_adc_rx with hand-computed expected pairs
module tb_audio_adc_rx;
  logic clk = 1'b0, rst = 1'b1;
  logic aud_bclk = 1'b0, aud_adclrck = 1'b0, aud_adcdat = 1'b0;
  logic enable = 1'b1, sample_ready = 1'b1;
  logic [15:0] left_data, right_data;
  logic sample_valid, overrun, frame_err;
  int checks = 0, failures = 0;
  int rises = 0, ovs = 0, fes = 0;
  logic vprev = 1'b0;
  logic [15:0] cap_l = '0, cap_r = '0;

  always #5 clk = ~clk;

  audio_adc_rx dut (
    .clk(clk),
    .rst(rst),
    .aud_bclk(aud_bclk),
    .aud_adclrck(aud_adclrck),
    .aud_adcdat(aud_adcdat),
    .enable(enable),
    .left_data(left_data),
    .right_data(right_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun(overrun),
    .frame_err(frame_err)
  );

  always @(negedge clk) begin
    vprev <= sample_valid;
    if (sample_valid && !vprev) begin
      rises <= rises + 1;
      cap_l <= left_data;
      cap_r <= right_data;
    end
    if (overrun) ovs <= ovs + 1;
    if (frame_err) fes <= fes + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_chan(input logic ch, input int n, input int w, input logic [31:0] d);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      aud_bclk = 1'b0;
      aud_adclrck = ch;
      aud_adcdat = (i >= 1 && i <= w) ? d[w-i] : 1'b0;
      #40;
      aud_bclk = 1'b1;
      #40;
    end
  endtask

  task automatic send_frame(input int n, input int w, input logic [31:0] l, input logic [31:0] r);
    send_chan(1'b0, n, w, l);
    send_chan(1'b1, n, w, r);
  endtask

  task automatic start_stream();
    send_chan(1'b1, 1, 0, 32'h0);
  endtask

  task automatic tail();
    send_chan(1'b0, 1, 0, 32'h0);
    wait_clks(10);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clks(3);
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", sample_valid); end
    checks++; if (left_data !== 16'h0) begin failures++; $display("FAIL reset_left got=%h exp=0000", left_data); end
    checks++; if (right_data !== 16'h0) begin failures++; $display("FAIL reset_right got=%h exp=0000", right_data); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int r0, o0, f0, lat;
    reset_dut();
    r0 = rises; o0 = ovs; f0 = fes; lat = 0;
    start_stream();
    send_frame(32, 16, 32'h1234, 32'hABCD);
    @(negedge clk);
    aud_bclk = 1'b0;
    aud_adclrck = 1'b0;
    aud_adcdat = 1'b0;
    #40;
    aud_bclk = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      if (sample_valid && lat == 0) lat = n;
    end
    wait_clks(2);
    checks++; if (lat !== 4) begin failures++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    checks++; if (rises - r0 !== 1) begin failures++; $display("FAIL basic_valid_count got=%0d exp=1", rises - r0); end
    checks++; if (cap_l !== 16'h1234) begin failures++; $display("FAIL basic_left got=%h exp=1234", cap_l); end
    checks++; if (cap_r !== 16'hABCD) begin failures++; $display("FAIL basic_right got=%h exp=abcd", cap_r); end
    checks++; if (fes - f0 !== 0) begin failures++; $display("FAIL basic_frame_err got=%0d exp=0", fes - f0); end
    checks++; if (ovs - o0 !== 0) begin failures++; $display("FAIL basic_overrun got=%0d exp=0", ovs - o0); end
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_after_accept got=%b exp=0", sample_valid); end
  endtask

  task automatic test_24bit();
    int r0;
    reset_dut();
    r0 = rises;
    start_stream();
    send_frame(32, 24, 32'h123456, 32'h89ABCD);
    tail();
    checks++; if (rises - r0 !== 1) begin failures++; $display("FAIL w24_valid_count got=%0d exp=1", rises - r0); end
    checks++; if (cap_l !== 16'h1234) begin failures++; $display("FAIL w24_left got=%h exp=1234", cap_l); end
    checks++; if (cap_r !== 16'h89AB) begin failures++; $display("FAIL w24_right got=%h exp=89ab", cap_r); end
  endtask

  task automatic test_overrun();
    int r0, o0;
    reset_dut();
    sample_ready = 1'b0;
    r0 = rises; o0 = ovs;
    start_stream();
    send_frame(32, 16, 32'h1111, 32'h2222);
    send_frame(32, 16, 32'h3333, 32'h4444);
    send_frame(32, 16, 32'h5555, 32'h6666);
    tail();
    checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid_held got=%b exp=1", sample_valid); end
    checks++; if (left_data !== 16'h1111) begin failures++; $display("FAIL ovr_left_held got=%h exp=1111", left_data); end
    checks++; if (right_data !== 16'h2222) begin failures++; $display("FAIL ovr_right_held got=%h exp=2222", right_data); end
    checks++; if (ovs - o0 !== 2) begin failures++; $display("FAIL ovr_pulse_count got=%0d exp=2", ovs - o0); end
    checks++; if (rises - r0 !== 1) begin failures++; $display("FAIL ovr_valid_count got=%0d exp=1", rises - r0); end
    @(negedge clk);
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL ovr_accept_drop got=%b exp=0", sample_valid); end
    sample_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int r0, f0;
    @(negedge clk);
    rst = 1'b1;
    r0 = rises;
    send_chan(1'b0, 32, 16, 32'h1111);
    fork
      send_chan(1'b1, 32, 16, 32'h2222);
      begin
        repeat (100) @(negedge clk);
        rst = 1'b0;
      end
    join
    f0 = fes;
    send_frame(32, 16, 32'h5A5A, 32'hC3C3);
    tail();
    checks++; if (rises - r0 !== 1) begin failures++; $display("FAIL rmid_valid_count got=%0d exp=1", rises - r0); end
    checks++; if (cap_l !== 16'h5A5A) begin failures++; $display("FAIL rmid_left got=%h exp=5a5a", cap_l); end
    checks++; if (cap_r !== 16'hC3C3) begin failures++; $display("FAIL rmid_right got=%h exp=c3c3", cap_r); end
    checks++; if (fes - f0 !== 0) begin failures++; $display("FAIL rmid_frame_err got=%0d exp=0", fes - f0); end
  endtask

  task automatic test_short();
    int r0, f0;
    reset_dut();
    r0 = rises; f0 = fes;
    start_stream();
    send_frame(8, 8, 32'hA5, 32'h5A);
    wait_clks(10);
    checks++; if (fes - f0 !== 1) begin failures++; $display("FAIL short_frame_err got=%0d exp=1", fes - f0); end
    checks++; if (rises - r0 !== 0) begin failures++; $display("FAIL short_no_valid got=%0d exp=0", rises - r0); end
    send_frame(32, 16, 32'h0102, 32'h0304);
    send_frame(32, 16, 32'h0506, 32'h0708);
    tail();
    checks++; if (rises - r0 !== 2) begin failures++; $display("FAIL short_resume_count got=%0d exp=2", rises - r0); end
    checks++; if (cap_l !== 16'h0506) begin failures++; $display("FAIL short_resume_left got=%h exp=0506", cap_l); end
    checks++; if (cap_r !== 16'h0708) begin failures++; $display("FAIL short_resume_right got=%h exp=0708", cap_r); end
  endtask

  task automatic test_slot();
    int f0, r0;
    reset_dut();
    f0 = fes; r0 = rises;
    start_stream();
    send_chan(1'b0, 32, 16, 32'h7777);
    wait_clks(8);
    checks++; if (fes - f0 !== 0) begin failures++; $display("FAIL slot_early_err got=%0d exp=0", fes - f0); end
    send_chan(1'b0, 8, 0, 32'h0);
    wait_clks(8);
    checks++; if (fes - f0 !== 1) begin failures++; $display("FAIL slot_err got=%0d exp=1", fes - f0); end
    checks++; if (rises - r0 !== 0) begin failures++; $display("FAIL slot_no_valid got=%0d exp=0", rises - r0); end
  endtask

  task automatic test_rst_mid_word();
    reset_dut();
    sample_ready = 1'b0;
    start_stream();
    send_frame(32, 16, 32'h0F0F, 32'hF0F0);
    fork
      send_chan(1'b0, 32, 16, 32'h1234);
      begin
        repeat (60) @(negedge clk);
        checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL rword_valid_before got=%b exp=1", sample_valid); end
        checks++; if (left_data !== 16'h0F0F) begin failures++; $display("FAIL rword_left_before got=%h exp=0f0f", left_data); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL rword_valid got=%b exp=0", sample_valid); end
        checks++; if (left_data !== 16'h0) begin failures++; $display("FAIL rword_left got=%h exp=0000", left_data); end
        checks++; if (right_data !== 16'h0) begin failures++; $display("FAIL rword_right got=%h exp=0000", right_data); end
        checks++; if ({overrun, frame_err} !== 2'b00) begin failures++; $display("FAIL rword_pulses got=%b exp=00", {overrun, frame_err}); end
      end
    join
    @(negedge clk);
    rst = 1'b0;
    sample_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_24bit();
    test_overrun();
    test_reset_mid();
    test_short();
    test_slot();
    test_rst_mid_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
